seq_run_ctrl: RTL and testbench

SEQ_RUN_CTRL -- requirements
Module: seq_run_ctrl

---
 rtl/seq_run_ctrl.sv | 82 ++++++++
 tb/tb_seq_run_ctrl.sv | 112 +++++++++++
 2 files changed

// File: rtl/seq_run_ctrl.sv
// seq_run_ctrl: serializes a latched NBITS word and flags runs of consecutive ones.
// Ports: clk_2/reset_n (clock, async active-low reset); start, word_in, run_len,
// msb_first (transaction request and its parameters, captured when start is accepted);
// busy, done, bit_valid, bit_out (transaction status and serial bit stream);
// match, match_count (run-length detection per bit and saturating per-transaction total).
module seq_run_ctrl #(
  parameter int NBITS = 8,
  parameter int NCNT  = 4
) (
  input  logic             clk_2,
  input  logic             reset_n,
  input  logic             start,
  input  logic [NBITS-1:0] word_in,
  input  logic [2:0]       run_len,
  input  logic             msb_first,
  output logic             busy,
  output logic             done,
  output logic             bit_valid,
  output logic             bit_out,
  output logic             match,
  output logic [NCNT-1:0]  match_count
);
  localparam int IW = $clog2(NBITS + 1);
  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_e;
  state_e state_q, state_d;
  logic [NBITS-1:0] word_q, word_d;
  logic [2:0] len_q, len_d, run_q, run_d, eff_len;
  logic msb_q, msb_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [NCNT-1:0] cnt_q, cnt_d;
  logic accept, cur_bit, last_bit;
  always_ff @(posedge clk_2 or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      word_q  <= '0;
      len_q   <= '0;
      msb_q   <= 1'b0;
      run_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      len_q   <= len_d;
      msb_q   <= msb_d;
      run_q   <= run_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
    end
  end
  assign accept   = (state_q == IDLE) && start;
  assign last_bit = idx_q == IW'(NBITS - 1);
  // The word register shifts toward the exit end, so the current bit is always at one end.
  assign cur_bit  = msb_q ? word_q[NBITS-1] : word_q[0];
  assign eff_len  = (len_q == 3'd0) ? 3'd1 : len_q;
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  state_d = start ? LOAD : IDLE;
      LOAD:  state_d = SHIFT;
      SHIFT: state_d = last_bit ? DONE : SHIFT;
      DONE:  state_d = IDLE;
    endcase
  end
  // Parameters are captured at the accepting edge so LOAD-cycle input changes cannot leak in.
  always_comb begin
    word_d = accept ? word_in : (state_q == SHIFT) ? (msb_q ? word_q << 1 : word_q >> 1) : word_q;
    len_d  = accept ? run_len : len_q;
    msb_d  = accept ? msb_first : msb_q;
    idx_d  = accept ? '0 : (state_q == SHIFT) ? idx_q + 1'b1 : idx_q;
    run_d  = accept ? '0 : (state_q != SHIFT) ? run_q : !cur_bit ? 3'd0 : (run_q == 3'd7) ? run_q : run_q + 3'd1;
    cnt_d  = accept ? '0 : (match && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
  end
  always_comb begin
    busy        = state_q != IDLE;
    done        = state_q == DONE;
    bit_valid   = state_q == SHIFT;
    bit_out     = bit_valid && cur_bit;
    match       = bit_out && (({1'b0, run_q} + 4'd1) >= {1'b0, eff_len});
    match_count = cnt_q;
  end
endmodule

// File: tb/tb_seq_run_ctrl.sv
// tb_seq_run_ctrl: scoreboard bench for seq_run_ctrl with directed transactions.
module tb_seq_run_ctrl;
  localparam int NBITS = 8;
  localparam int NCNT  = 4;
  logic clk_2 = 1'b0;
  logic reset_n = 1'b0;
  logic start = 1'b0;
  logic [NBITS-1:0] word_in = '0;
  logic [2:0] run_len = '0;
  logic msb_first = 1'b0;
  logic busy, done, bit_valid, bit_out, match;
  logic [NCNT-1:0] match_count;
  int checks = 0;
  int failures = 0;
  logic [1:0] bit_q[$];
  logic [NCNT-1:0] cnt_q[$];

  seq_run_ctrl #(.NBITS(NBITS), .NCNT(NCNT)) dut (
    .clk_2(clk_2), .reset_n(reset_n), .start(start), .word_in(word_in),
    .run_len(run_len), .msb_first(msb_first), .busy(busy), .done(done),
    .bit_valid(bit_valid), .bit_out(bit_out), .match(match), .match_count(match_count)
  );

  always #5 clk_2 = ~clk_2;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk_2) begin
    if (reset_n) begin
      if (bit_valid) begin
        if (bit_q.size() == 0) chk("unexpected_bit", 1, 0);
        else begin
          logic [1:0] e;
          e = bit_q.pop_front();
          chk("bit_out", int'(bit_out), int'(e[1]));
          chk("match", int'(match), int'(e[0]));
        end
      end else begin
        chk("idle_bit_match", int'({bit_out, match}), 0);
      end
      if (done) begin
        if (cnt_q.size() == 0) chk("unexpected_done", 1, 0);
        else chk("match_count", int'(match_count), int'(cnt_q.pop_front()));
      end
    end
  end

  task automatic issue(input logic [7:0] w, input logic [2:0] rl, input logic msb,
                       input logic [7:0] mask, input int cnt);
    @(negedge clk_2);
    word_in = w; run_len = rl; msb_first = msb; start = 1'b1;
    for (int i = 0; i < NBITS; i++) bit_q.push_back({msb ? w[NBITS-1-i] : w[i], mask[i]});
    cnt_q.push_back(NCNT'(cnt));
    @(negedge clk_2);
    start = 1'b0;
    chk("load_busy", int'(busy), 1);
    chk("load_count_clear", int'(match_count), 0);
  endtask

  task automatic run_txn(input logic [7:0] w, input logic [2:0] rl, input logic msb,
                         input logic [7:0] mask, input int cnt, input bit poke);
    issue(w, rl, msb, mask, cnt);
    for (int k = 2; k <= NBITS + 3; k++) begin
      @(negedge clk_2);
      if (k == 2) begin word_in = ~w; run_len = 3'd7 - rl; msb_first = ~msb; end
      start = poke && (k == 4 || k == NBITS + 2);
      chk("done_timing", int'(done), int'(k == NBITS + 2));
      chk("busy_timing", int'(busy), int'(k <= NBITS + 2));
    end
    start = 1'b0;
    @(negedge clk_2);
    chk("no_extra_txn", int'(busy), 0);
    chk("queues_drained", bit_q.size() + cnt_q.size(), 0);
  endtask

  initial begin
    #1;
    chk("rst_outputs", int'({busy, done, bit_valid, bit_out, match, match_count}), 0);
    repeat (2) @(negedge clk_2);
    reset_n = 1'b1;
    run_txn(8'hFF, 3'd3, 1'b1, 8'hFC, 6, 1'b0);
    run_txn(8'hB7, 3'd3, 1'b1, 8'h80, 1, 1'b0);
    run_txn(8'hB7, 3'd3, 1'b0, 8'h04, 1, 1'b0);
    run_txn(8'h0F, 3'd2, 1'b0, 8'h0E, 3, 1'b0);
    run_txn(8'h55, 3'd0, 1'b0, 8'h55, 4, 1'b0);
    run_txn(8'hFF, 3'd7, 1'b1, 8'hC0, 2, 1'b0);
    run_txn(8'hFF, 3'd1, 1'b1, 8'hFF, 8, 1'b0);
    run_txn(8'hFF, 3'd1, 1'b1, 8'hFF, 8, 1'b0);
    run_txn(8'hA5, 3'd1, 1'b1, 8'hA5, 4, 1'b1);
    issue(8'hFF, 3'd1, 1'b1, 8'hFF, 8);
    for (int k = 2; k <= 5; k++) @(negedge clk_2);
    reset_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({busy, done, bit_valid, bit_out, match, match_count}), 0);
    bit_q.delete();
    cnt_q.delete();
    for (int k = 0; k < NBITS; k++) begin
      @(negedge clk_2);
      chk("midrst_no_done", int'(done), 0);
    end
    reset_n = 1'b1;
    run_txn(8'h0F, 3'd2, 1'b0, 8'h0E, 3, 1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
